spi_fifo_bridge: RTL
====================

// Module: spi_fifo_bridge
// PURPOSE
//  Byte-stream buffer between the 68k SPI register decode and the SPI master.
//  CPU writes land in a TX FIFO. Each entry holds 8 data bits plus a DC tag.
//  The block drains the FIFO into the master's TX handshake and drives DC for the byte in flight.
//  Received bytes are buffered for CPU reads, so display/SD bursts no longer poll TX_Ready per byte.
// PARAMETERS
//  TX_AW   4   TX FIFO address width; depth = 2**TX_AW entries of {dc,byte}
//  RX_AW   4   RX FIFO address width; depth = 2**RX_AW bytes (used only with SPI_FIFO_RX_EN)
// PORTS
//  clk          in   1        system clock, same as the SPI master
//  rst_h        in   1        asynchronous active-high reset
//  wr_stb       in   1        1-cycle push strobe from CPU decode
//  wr_data      in   8        byte to send
//  wr_dc        in   1        DC tag for this byte (1=data, 0=cmd)
//  rd_stb       in   1        1-cycle pop strobe for RX
//  rd_data      out  8        RX head byte (registered)
//  tx_full      out  1        TX FIFO full
//  tx_empty     out  1        TX FIFO empty
//  tx_level     out  TX_AW+1  TX entries stored
//  busy         out  1        TX FIFO non-empty or FSM not IDLE
//  rx_avail     out  1        RX holds >=1 byte
//  rx_overflow  out  1        sticky: RX byte dropped
//  ovf_clr      in   1        clears rx_overflow
//  m_tx_byte    out  8        to SPI master i_TX_Byte
//  m_tx_dv      out  1        to SPI master i_TX_DV, 1-cycle pulse
//  m_tx_ready   in   1        from SPI master o_TX_Ready
//  m_rx_dv      in   1        from SPI master o_RX_DV, 1-cycle pulse
//  m_rx_byte    in   8        from SPI master o_RX_Byte
//  dc           out  1        DC pin, held stable for the whole byte
// BEHAVIOUR
//  Reset values:
//   - m_tx_dv=0, m_tx_byte=0, dc=0, rd_data=0, rx_overflow=0.
//   - Both FIFOs empty: tx_empty=1, tx_full=0, tx_level=0, rx_avail=0.
//   - FSM=IDLE.
//  TX push: wr_stb with tx_full=0 writes {wr_dc,wr_data}.
//   - Full is judged on the pre-edge level.
//   - A push while full is dropped, even if a pop occurs in the same cycle.
//   - Simultaneous push and pop: level unchanged. Pointers wrap modulo 2**TX_AW.
//  FSM:
//   - IDLE -> ISSUE when tx_empty=0 and m_tx_ready=1.
//     On that edge, register m_tx_byte and dc from the head, pop the head, set m_tx_dv=1.
//   - ISSUE (1 cycle, m_tx_dv=1) -> WAIT_BUSY; m_tx_dv returns to 0.
//   - WAIT_BUSY -> WAIT_DONE on m_tx_ready=0.
//   - WAIT_DONE -> IDLE on m_tx_ready=1.
//  Latency and throughput:
//   - Push at edge N into an empty FIFO, FSM idle, ready high: m_tx_dv is high during cycle N+1..N+2 (first-word latency 2 clk).
//   - Back-to-back gap is at least 1 IDLE cycle.
//   - dc changes only on IDLE->ISSUE. It is never altered while the master is busy.
//  RX capture:
//   - m_rx_dv writes m_rx_byte. Every rx pulse is captured, including those from bytes in flight across reset release.
//   - rd_data always presents the head. rd_stb with rx_avail=1 pops.
//   - rd_stb on empty: no state change, rd_data keeps its last value.
//   - m_rx_dv and rd_stb in the same cycle: both act.
//   - When full, a pop in the same cycle frees the slot and the byte is kept.
//   - m_rx_dv with RX full and no pop: byte dropped, rx_overflow set.
//   - ovf_clr and a new overflow in the same cycle: set wins.
//  Reset mid-transfer:
//   - The FSM returns to IDLE and both FIFOs flush.
//   - The glue resets the SPI master from the same source, so no handshake is left half-open.
// CONFIGURATION
//  SPI_FIFO_RX_EN defined:
//   - RX path is a 2**RX_AW-deep FIFO as above.
//  SPI_FIFO_RX_EN undefined:
//   - RX path is a single holding register. m_rx_dv always overwrites it and sets rx_avail.
//   - If rx_avail was already 1 and no rd_stb occurs that cycle, rx_overflow is set.
//   - rd_stb clears rx_avail. RX_AW is ignored.
//  The TX path is identical in both builds.
// TESTING
//  1. Reset, push 0xA5 dc=1, model master drops ready 1 clk after dv and raises it 16 clk later
//     -> one m_tx_dv pulse at N+2, m_tx_byte=0xA5, dc=1 until ready returns, then busy=0.
//  2. Push 16 bytes 0x00..0x0F with ready held 0, then push 0xFF
//     -> tx_full=1, tx_level=16, 0xFF dropped.
//     Release ready -> bytes leave in order 0x00..0x0F, 16 dv pulses, no 0xFF.
//  3. Alternate dc 0,1,0 on bytes 0x2A,0x00,0x2B
//     -> dc toggles only on IDLE->ISSUE edges, never while ready=0.
//  4. (RX_EN) 17 m_rx_dv pulses 0x10..0x20 with no reads
//     -> rx_overflow=1. Reads return 0x10..0x1F, then rx_avail=0. ovf_clr clears the flag.
//  5. (no RX_EN) rx 0x55 then 0x66 without read
//     -> rd_data=0x66, rx_overflow=1. Repeat with rd_stb coincident with the 2nd dv -> rx_overflow=0.
//  6. Assert rst_h during WAIT_DONE with 3 entries queued
//     -> same-cycle async clear: tx_empty=1, m_tx_dv=0, dc=0. No dv after release until a new push.

Source files
------------

// File: rtl/spi_fifo_bridge_if.sv
// spi_fifo_bridge_if
//   Bundles every non-clock signal of spi_fifo_bridge: the CPU decode side
//   (push/pop strobes, status), the SPI master side (TX handshake, RX pulse)
//   and the DC pin.
//
//   Handshake semantics, in one place:
//     - wr_stb, rd_stb, ovf_clr, m_tx_dv and m_rx_dv are single-cycle strobes
//       sampled on the rising clk edge. There is no back-pressure on them:
//       a wr_stb while tx_full is dropped and an rd_stb while rx_avail=0 is
//       ignored.
//     - m_tx_ready is the master's level-sensitive "idle" flag. A byte is
//       offered (m_tx_dv for one cycle) only when m_tx_ready was high. The
//       master drops it to show the byte is in flight and raises it when the
//       byte is finished.
//
//   Modports:
//     slave  - the bridge's view (drives status, TX byte/dv, dc, state_dbg)
//     master - the environment's view (CPU decode plus SPI master)
//
//   state_dbg carries the TX FSM state (0 IDLE, 1 ISSUE, 2 WAIT_BUSY,
//   3 WAIT_DONE) for observation only.
interface spi_fifo_bridge_if #(
  parameter int TX_AW = 4
);
  logic             wr_stb;
  logic [7:0]       wr_data;
  logic             wr_dc;
  logic             rd_stb;
  logic [7:0]       rd_data;
  logic             tx_full;
  logic             tx_empty;
  logic [TX_AW:0]   tx_level;
  logic             busy;
  logic             rx_avail;
  logic             rx_overflow;
  logic             ovf_clr;
  logic [7:0]       m_tx_byte;
  logic             m_tx_dv;
  logic             m_tx_ready;
  logic             m_rx_dv;
  logic [7:0]       m_rx_byte;
  logic             dc;
  logic [1:0]       state_dbg;

  modport slave (
    input  wr_stb, wr_data, wr_dc, rd_stb, ovf_clr,
    input  m_tx_ready, m_rx_dv, m_rx_byte,
    output rd_data, tx_full, tx_empty, tx_level, busy, rx_avail, rx_overflow,
    output m_tx_byte, m_tx_dv, dc, state_dbg
  );

  modport master (
    output wr_stb, wr_data, wr_dc, rd_stb, ovf_clr,
    output m_tx_ready, m_rx_dv, m_rx_byte,
    input  rd_data, tx_full, tx_empty, tx_level, busy, rx_avail, rx_overflow,
    input  m_tx_byte, m_tx_dv, dc, state_dbg
  );
endinterface

// File: rtl/spi_fifo_bridge.sv
// spi_fifo_bridge
//   Byte-stream buffer between the CPU SPI register decode and an SPI master.
//   CPU pushes {dc,byte} into a TX FIFO; a small FSM drains it into the
//   master's TX handshake and holds the DC pin for the byte in flight.
//   Received bytes are buffered for CPU reads.
//
//   Ports:
//     clk    system clock (shared with the SPI master)
//     rst_h  asynchronous active-high reset; flushes both FIFOs, FSM -> IDLE
//     bus    spi_fifo_bridge_if.slave (see interface header for signals)
//
//   Parameters:
//     TX_AW  TX FIFO address width, depth 2**TX_AW entries of {dc,byte}
//     RX_AW  RX FIFO address width, depth 2**RX_AW bytes (RX FIFO build only)
//
//   Build option:
//     SPI_FIFO_RX_EN defined   -> RX path is a 2**RX_AW deep FIFO
//     SPI_FIFO_RX_EN undefined -> RX path is a single holding register
//   The TX path is identical in both builds.
module spi_fifo_bridge #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic               clk,
  input  logic               rst_h,
  spi_fifo_bridge_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int TX_DEPTH = 1 << TX_AW;

  // ---------------------------------------------------------------- TX FIFO
  logic [8:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr;
  logic [TX_AW-1:0] tx_rd_ptr;
  logic [TX_AW:0]   tx_count;
  logic             tx_full;
  logic             tx_empty;
  logic             tx_push;
  logic             tx_pop;

  state_t state;
  state_t state_next;

  assign tx_full  = (tx_count == (TX_AW+1)'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);
  // Full is judged before the edge, so a push while full is lost even when
  // the FSM pops in the same cycle.
  assign tx_push  = bus.wr_stb && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= {bus.wr_dc, bus.wr_data};
    end
  end

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ----------------------------------------------------------------- TX FSM
  logic       tx_dv_q;
  logic [7:0] tx_byte_q;
  logic       dc_q;

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tx_pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty && bus.m_tx_ready) begin
          state_next = ISSUE;
          tx_pop     = 1'b1;
        end
      end
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (!bus.m_tx_ready) state_next = WAIT_DONE;
      WAIT_DONE: if (bus.m_tx_ready)  state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Byte and dc are loaded only on the IDLE->ISSUE edge, so dc stays put for
  // the whole time the master is shifting.
  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      dc_q      <= 1'b0;
    end else begin
      tx_dv_q <= tx_pop;
      if (tx_pop) begin
        {dc_q, tx_byte_q} <= tx_mem[tx_rd_ptr];
      end
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [7:0] rd_data_q;
  logic       rx_avail_w;
  logic       rx_ovf_set;
  logic       rx_ovf_q;

`ifdef SPI_FIFO_RX_EN
  localparam int RX_DEPTH = 1 << RX_AW;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr;
  logic [RX_AW-1:0] rx_rd_ptr;
  logic [RX_AW-1:0] rx_rd_ptr_next;
  logic [RX_AW:0]   rx_count;
  logic [RX_AW:0]   rx_count_next;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_push;
  logic             rx_pop;
  logic [7:0]       rx_head_next;

  assign rx_full    = (rx_count == (RX_AW+1)'(RX_DEPTH));
  assign rx_empty   = (rx_count == '0);
  assign rx_pop     = bus.rd_stb && !rx_empty;
  // A pop in the same cycle frees the slot, so a byte arriving while full
  // is still kept in that case.
  assign rx_push    = bus.m_rx_dv && (!rx_full || rx_pop);
  assign rx_ovf_set = bus.m_rx_dv && rx_full && !rx_pop;
  assign rx_avail_w = !rx_empty;

  assign rx_rd_ptr_next = rx_rd_ptr + RX_AW'(rx_pop);

  always_comb begin
    rx_count_next = rx_count;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_next = rx_count + 1'b1;
      2'b01:   rx_count_next = rx_count - 1'b1;
      default: rx_count_next = rx_count;
    endcase
  end

  // rd_data is a register that always holds the head. The next head is the
  // byte being written right now when it lands exactly at the new read
  // pointer (empty FIFO, or the last entry popped); otherwise it is already
  // in memory. An empty FIFO keeps the last value.
  always_comb begin
    rx_head_next = rd_data_q;
    if (rx_count_next != '0) begin
      if (rx_push && (rx_rd_ptr_next == rx_wr_ptr)) begin
        rx_head_next = bus.m_rx_byte;
      end else begin
        rx_head_next = rx_mem[rx_rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= bus.m_rx_byte;
    end
  end

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      rd_data_q <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      rx_rd_ptr <= rx_rd_ptr_next;
      rx_count  <= rx_count_next;
      rd_data_q <= rx_head_next;
    end
  end
`else
  logic rx_avail_q;

  // Single holding register: a new byte always overwrites; losing an unread
  // byte is an overflow unless the CPU reads in that same cycle.
  assign rx_ovf_set = bus.m_rx_dv && rx_avail_q && !bus.rd_stb;
  assign rx_avail_w = rx_avail_q;

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      rd_data_q  <= '0;
      rx_avail_q <= 1'b0;
    end else begin
      if (bus.m_rx_dv) begin
        rd_data_q  <= bus.m_rx_byte;
        rx_avail_q <= 1'b1;
      end else if (bus.rd_stb) begin
        rx_avail_q <= 1'b0;
      end
    end
  end
`endif

  // Sticky overflow; a new overflow wins over a coincident clear.
  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      rx_ovf_q <= 1'b0;
    end else if (rx_ovf_set) begin
      rx_ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      rx_ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.tx_full     = tx_full;
  assign bus.tx_empty    = tx_empty;
  assign bus.tx_level    = tx_count;
  assign bus.busy        = !tx_empty || (state != IDLE);
  assign bus.m_tx_dv     = tx_dv_q;
  assign bus.m_tx_byte   = tx_byte_q;
  assign bus.dc          = dc_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rx_avail    = rx_avail_w;
  assign bus.rx_overflow = rx_ovf_q;
  assign bus.state_dbg   = state;

endmodule
